// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master arbiter for the single data-memory port with in-order response routing
// Ports: clk_i/rst_i (sync active-high); m_req_i/m_gnt_o/m_rvalid_o per-master handshake;
// m_addr_i/m_we_i/m_be_i/m_wdata_i per-master request fields; m_rdata_o broadcast response data;
// data_* memory-side port; outstanding_o granted-but-unanswered count; err_o sticky rvalid-when-empty error.
// Optional feature: define DATA_MEM_ARB_RR_EN for round-robin tie-breaking (default: master 0 wins ties).
module data_mem_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 m_req_i,
    output logic [1:0]                 m_gnt_o,
    output logic [1:0]                 m_rvalid_o,
    input  logic [1:0][DATA_WIDTH-1:0] m_addr_i,
    input  logic [1:0]                 m_we_i,
    input  logic [1:0][3:0]            m_be_i,
    input  logic [1:0][DATA_WIDTH-1:0] m_wdata_i,
    output logic [DATA_WIDTH-1:0]      m_rdata_o,
    output logic                       data_req_o,
    input  logic                       data_gnt_i,
    input  logic                       data_rvalid_i,
    output logic [DATA_WIDTH-1:0]      data_addr_o,
    output logic                       data_we_o,
    output logic [3:0]                 data_be_o,
    output logic [DATA_WIDTH-1:0]      data_wdata_o,
    input  logic [DATA_WIDTH-1:0]      data_rdata_i,
    output logic [CW-1:0]              outstanding_o,
    output logic                       err_o
);
    logic                       locked, locked_id, rr_last, err, tie, sel, full, empty, gnt, pop;
    logic [CW-1:0]              count;
    logic [PW-1:0]              wptr, rptr;
    logic [MAX_OUTSTANDING-1:0] fifo;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef DATA_MEM_ARB_RR_EN
    assign tie = ~rr_last;
`else
    // rr_last is tracked regardless of policy; fixed priority simply ignores it
    assign tie = 1'b0 & rr_last;
`endif

    always_comb begin
        full         = count == CW'(MAX_OUTSTANDING);
        empty        = count == '0;
        // master 1 is chosen when it requests alone, or on a tie the policy hands to it
        sel          = locked ? locked_id : (m_req_i[1] & (~m_req_i[0] | tie));
        data_req_o   = m_req_i[sel] & ~full;
        gnt          = data_req_o & data_gnt_i;
        pop          = data_rvalid_i & ~empty;
        m_gnt_o      = {gnt & sel, gnt & ~sel};
        m_rvalid_o   = {pop & fifo[rptr], pop & ~fifo[rptr]};
        m_rdata_o    = data_rdata_i;
        data_addr_o  = m_addr_i[sel];
        data_we_o    = m_we_i[sel];
        data_be_o    = m_be_i[sel];
        data_wdata_o = m_wdata_i[sel];
        outstanding_o = count;
        err_o        = err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            locked    <= 1'b0;
            locked_id <= 1'b0;
            rr_last   <= 1'b1;
            err       <= 1'b0;
        end else begin
            if (gnt) begin
                fifo[wptr] <= sel;
                wptr       <= nxt(wptr);
                rr_last    <= sel;
                locked     <= 1'b0;
            end else if (data_req_o) begin
                locked    <= 1'b1;
                locked_id <= sel;
            end
            if (pop)
                rptr <= nxt(rptr);
            if (data_rvalid_i & empty)
                err <= 1'b1;
            count <= count + CW'(gnt) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized bench against a queue-based reference model of the arbiter
module tb_data_mem_arbiter;
    localparam int DW = 32;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);
`ifdef DATA_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         m_req, m_gnt, m_rvalid, m_we;
    logic [1:0][DW-1:0] m_addr, m_wdata;
    logic [1:0][3:0]    m_be;
    logic [DW-1:0]      m_rdata, d_addr, d_wdata, d_rdata;
    logic               d_req, d_gnt, d_rvalid, d_we, err;
    logic [3:0]         d_be;
    logic [CW-1:0]      outstanding;

    data_mem_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
        .data_req_o(d_req), .data_gnt_i(d_gnt), .data_rvalid_i(d_rvalid), .data_addr_o(d_addr),
        .data_we_o(d_we), .data_be_o(d_be), .data_wdata_o(d_wdata), .data_rdata_i(d_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // reference model: in-flight sources in issue order, the frozen choice of a stalled request
    int q[$];
    int hold;
    int rr_last;
    bit m_err;
    bit pend[2];

    function automatic int pick();
        if (hold >= 0) return hold;
        if (m_req == 2'b11) return RR ? 1 - rr_last : 0;
        return m_req == 2'b10 ? 1 : 0;
    endfunction

    task automatic model_reset();
        q.delete();
        hold = -1;
        rr_last = 1;
        m_err = 0;
    endtask

    task automatic step(input int p_req, input int p_gnt, input int p_rv, input int p_rst);
        int s;
        bit ereq, egnt;
        logic [1:0] erv;
        for (int m = 0; m < 2; m++)
            if (!pend[m] && $urandom_range(0, 99) < p_req) begin
                pend[m] = 1;
                m_addr[m] = $urandom;
                m_wdata[m] = $urandom;
                m_we[m] = $urandom_range(0, 1);
                m_be[m] = $urandom_range(0, 15);
            end
        m_req = {pend[1], pend[0]};
        d_gnt = $urandom_range(0, 99) < p_gnt;
        d_rvalid = (q.size() > 0) ? ($urandom_range(0, 99) < p_rv) : ($urandom_range(0, 199) == 0);
        d_rdata = $urandom;
        rst = $urandom_range(0, 999) < p_rst;
        #2;
        s = pick();
        ereq = m_req[s] && q.size() < MO;
        egnt = ereq && d_gnt;
        erv = (d_rvalid && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
        chk("data_req", d_req, ereq);
        chk("m_gnt", m_gnt, egnt ? 2'(1 << s) : 2'b00);
        chk("m_rvalid", m_rvalid, erv);
        chk("m_rdata", m_rdata, d_rdata);
        chk("data_addr", d_addr, m_addr[s]);
        chk("data_we", d_we, m_we[s]);
        chk("data_be", d_be, m_be[s]);
        chk("data_wdata", d_wdata, m_wdata[s]);
        chk("outstanding", outstanding, q.size());
        chk("err", err, m_err);
        @(posedge clk);
        if (egnt) pend[s] = 0;
        if (rst) model_reset();
        else begin
            if (d_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_err = 1;
            end
            if (egnt) begin
                q.push_back(s);
                rr_last = s;
                hold = -1;
            end else if (ereq) hold = s;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_req = '0; m_addr = '0; m_wdata = '0; m_we = '0; m_be = '0;
        d_gnt = 0; d_rvalid = 0; d_rdata = '0;
        pend[0] = 0; pend[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        // reset held with no traffic: every output in its idle state
        step(0, 0, 0, 1000);
        for (int i = 0; i < 3000; i++) step(40, 50, 40, 5);
        for (int i = 0; i < 2000; i++) step(95, 80, 30, 2);
        for (int i = 0; i < 2000; i++) step(70, 30, 60, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
